licznik_timer: RTL and testbench

//  Programmable timer/counter that is the source of timer_int for the interrupt controller.
//  The CPU configures it through a small write port. An 8-bit counter advances on prescaled ticks.
//  On overflow (free-run mode) or compare match (CTC mode) it emits a one-cycle timer_int pulse.
//  The interrupt controller latches that pulse; this block keeps no pending flag.

---
 rtl/licznik_timer.sv | 100 ++++++++++
 tb/tb_licznik_timer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/licznik_timer.sv
// Programmable 8-bit timer/counter with prescaler; emits a one-cycle timer_int pulse
// on overflow (free-run) or compare match (CTC).
module licznik_timer #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PRESC_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] cnt_value,
  output logic             timer_int
);

  localparam logic [1:0] AddrCtrl = 2'd0;
  localparam logic [1:0] AddrCmp  = 2'd1;
  localparam logic [1:0] AddrCnt  = 2'd2;

  typedef enum logic [0:0] {StStop, StRun} state_e;

  state_e               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [2:0]           psel_q, psel_d;
  logic [WIDTH-1:0]     cmp_q, cmp_d;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic                 int_q, int_d;
  logic [PRESC_W-1:0]   tick_mask;
  logic                 tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StStop;
      mode_q  <= 1'b0;
      psel_q  <= 3'd0;
      cmp_q   <= '0;
      cnt_q   <= '0;
      presc_q <= '0;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      psel_q  <= psel_d;
      cmp_q   <= cmp_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      int_q   <= int_d;
    end
  end

  // Tick when the low psel prescaler bits are all ones; psel=0 gives an empty mask.
  always_comb begin
    tick_mask = PRESC_W'((1 << psel_q) - 1);
    tick      = (state_q == StRun) && ((presc_q & tick_mask) == tick_mask);
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    psel_d  = psel_q;
    cmp_d   = cmp_q;
    cnt_d   = cnt_q;
    int_d   = 1'b0;
    presc_d = (state_q == StRun) ? presc_q + PRESC_W'(1) : '0;

    // The tick always uses the current CTRL/CMP; writes land for the next cycle.
    if (tick) begin
      if (mode_q && (cnt_q == cmp_q)) begin
        cnt_d = '0;
        int_d = 1'b1;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
        int_d = !mode_q && (cnt_q == '1);
      end
    end

    if (wr_en) begin
      case (wr_addr)
        AddrCtrl: begin
          state_d = wr_data[0] ? StRun : StStop;
          mode_d  = wr_data[1];
          psel_d  = wr_data[4:2];
          presc_d = '0;
        end
        AddrCmp: cmp_d = wr_data;
        AddrCnt: begin
          // A CNT write overrides a coincident tick, including its pulse.
          cnt_d = wr_data;
          int_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign cnt_value = cnt_q;
  assign timer_int = int_q;

endmodule

// File: tb/tb_licznik_timer.sv
// Directed self-checking bench for licznik_timer: free-run, CTC, prescaler, pause,
// write/tick collisions and asynchronous reset.
module tb_licznik_timer;

  localparam logic [1:0] ACTRL = 2'd0;
  localparam logic [1:0] ACMP  = 2'd1;
  localparam logic [1:0] ACNT  = 2'd2;
  localparam logic [1:0] ARSV  = 2'd3;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] cnt_value;
  logic       timer_int;

  int asserts;
  int errors;

  licznik_timer #(
    .WIDTH  (8),
    .PRESC_W(7)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cnt_value(cnt_value),
    .timer_int(timer_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each call leaves us 1 time unit after a rising edge, i.e. inside the next cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  // Stop, clear CNT, load CMP, then start with the given CTRL value.
  task automatic setup(input logic [7:0] cmp, input logic [7:0] ctrl);
    wr(ACTRL, 8'h00);
    wr(ACNT, 8'h00);
    wr(ACMP, cmp);
    wr(ACTRL, ctrl);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_en = 1'b0;
    wr_addr = 2'd0;
    wr_data = 8'h00;
    #3 rst = 1'b0;
    #1;
    asserts++;
    if (cnt_value !== 8'h00 || timer_int !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: cnt=%h int=%b, want cnt=00 int=0", cnt_value, timer_int);
    end
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      asserts++;
      if (cnt_value !== 8'h00 || timer_int !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: cnt=%h int=%b, want cnt=00 int=0", i, cnt_value,
                 timer_int);
      end
    end
  endtask

  task automatic test_reserved();
    wr(ARSV, 8'hFF);
    step();
    asserts++;
    if (cnt_value !== 8'h00 || timer_int !== 1'b0) begin
      errors++;
      $display("FAIL reserved_addr: cnt=%h int=%b, want cnt=00 int=0", cnt_value, timer_int);
    end
  endtask

  task automatic test_free_run();
    logic [7:0] exp_cnt [3];
    exp_cnt[0] = 8'hFE;
    exp_cnt[1] = 8'hFF;
    exp_cnt[2] = 8'h00;
    wr(ACNT, 8'hFD);
    asserts++;
    if (cnt_value !== 8'hFD) begin
      errors++;
      $display("FAIL cnt_write: cnt=%h, want fd", cnt_value);
    end
    wr(ACTRL, 8'h01);
    for (int i = 0; i < 3; i++) begin
      step();
      asserts++;
      if (cnt_value !== exp_cnt[i] || timer_int !== (i == 2)) begin
        errors++;
        $display("FAIL free_run[%0d]: cnt=%h int=%b, want cnt=%h int=%b", i, cnt_value,
                 timer_int, exp_cnt[i], (i == 2));
      end
    end
    for (int i = 1; i <= 255; i++) begin
      step();
      asserts++;
      if (cnt_value !== 8'(i) || timer_int !== 1'b0) begin
        errors++;
        $display("FAIL free_run_silent[%0d]: cnt=%h int=%b, want cnt=%h int=0", i, cnt_value,
                 timer_int, 8'(i));
      end
    end
    step();
    asserts++;
    if (cnt_value !== 8'h00 || timer_int !== 1'b1) begin
      errors++;
      $display("FAIL free_run_wrap2: cnt=%h int=%b, want cnt=00 int=1", cnt_value, timer_int);
    end
  endtask

  task automatic test_ctc();
    logic [7:0] exp;
    setup(8'd4, 8'h03);
    for (int i = 1; i <= 15; i++) begin
      step();
      exp = 8'(i % 5);
      asserts++;
      if (cnt_value !== exp || timer_int !== (exp == 8'd0)) begin
        errors++;
        $display("FAIL ctc[%0d]: cnt=%h int=%b, want cnt=%h int=%b", i, cnt_value, timer_int,
                 exp, (exp == 8'd0));
      end
    end
  endtask

  task automatic test_prescaler();
    logic [7:0] exp;
    setup(8'd1, 8'h0B);
    for (int k = 1; k <= 24; k++) begin
      step();
      exp = (k < 4) ? 8'd0 : 8'((k / 4) % 2);
      asserts++;
      if (cnt_value !== exp || timer_int !== (k % 8 == 0)) begin
        errors++;
        $display("FAIL presc[%0d]: cnt=%h int=%b, want cnt=%h int=%b", k, cnt_value, timer_int,
                 exp, (k % 8 == 0));
      end
    end
  endtask

  task automatic test_pause();
    logic [7:0] exp_cnt [3];
    exp_cnt[0] = 8'd3;
    exp_cnt[1] = 8'd4;
    exp_cnt[2] = 8'd0;
    setup(8'd4, 8'h03);
    step();
    // Stop written while cnt=1: that cycle's tick still lands, so cnt freezes at 2.
    wr(ACTRL, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step();
      asserts++;
      if (cnt_value !== 8'd2 || timer_int !== 1'b0) begin
        errors++;
        $display("FAIL pause_hold[%0d]: cnt=%h int=%b, want cnt=02 int=0", i, cnt_value,
                 timer_int);
      end
    end
    wr(ACTRL, 8'h03);
    for (int i = 0; i < 3; i++) begin
      step();
      asserts++;
      if (cnt_value !== exp_cnt[i] || timer_int !== (i == 2)) begin
        errors++;
        $display("FAIL pause_resume[%0d]: cnt=%h int=%b, want cnt=%h int=%b", i, cnt_value,
                 timer_int, exp_cnt[i], (i == 2));
      end
    end
  endtask

  task automatic test_collisions();
    setup(8'd4, 8'h03);
    for (int i = 0; i < 4; i++) step();
    wr(ACNT, 8'h10);
    asserts++;
    if (cnt_value !== 8'h10 || timer_int !== 1'b0) begin
      errors++;
      $display("FAIL cnt_wr_tick: cnt=%h int=%b, want cnt=10 int=0", cnt_value, timer_int);
    end
    // 0x10 -> wraps through 0 without a pulse (0xF0 ticks), then matches at 4.
    for (int i = 0; i < 8'hF0; i++) step();
    asserts++;
    if (cnt_value !== 8'h00 || timer_int !== 1'b0) begin
      errors++;
      $display("FAIL ctc_wrap_nopulse: cnt=%h int=%b, want cnt=00 int=0", cnt_value, timer_int);
    end
    for (int i = 0; i < 5; i++) step();
    asserts++;
    if (cnt_value !== 8'h00 || timer_int !== 1'b1) begin
      errors++;
      $display("FAIL ctc_after_wrap: cnt=%h int=%b, want cnt=00 int=1", cnt_value, timer_int);
    end
    for (int i = 0; i < 4; i++) step();
    wr(ACMP, 8'h00);
    asserts++;
    if (cnt_value !== 8'h00 || timer_int !== 1'b1) begin
      errors++;
      $display("FAIL cmp_wr_old: cnt=%h int=%b, want cnt=00 int=1", cnt_value, timer_int);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      asserts++;
      if (cnt_value !== 8'h00 || timer_int !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back[%0d]: cnt=%h int=%b, want cnt=00 int=1", i, cnt_value,
                 timer_int);
      end
    end
  endtask

  task automatic test_reset_mid();
    setup(8'd4, 8'h03);
    for (int i = 0; i < 3; i++) step();
    asserts++;
    if (cnt_value !== 8'd3) begin
      errors++;
      $display("FAIL pre_reset: cnt=%h, want 03", cnt_value);
    end
    #2 rst = 1'b0;
    #1;
    asserts++;
    if (cnt_value !== 8'h00 || timer_int !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: cnt=%h int=%b, want cnt=00 int=0", cnt_value, timer_int);
    end
    step();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      asserts++;
      if (cnt_value !== 8'h00 || timer_int !== 1'b0) begin
        errors++;
        $display("FAIL reset_release[%0d]: cnt=%h int=%b, want cnt=00 int=0", i, cnt_value,
                 timer_int);
      end
    end
  endtask

  initial begin
    asserts = 0;
    errors  = 0;
    test_reset();
    test_reserved();
    test_free_run();
    test_ctc();
    test_prescaler();
    test_pause();
    test_collisions();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
    $finish;
  end

endmodule
